memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Pipeline stage between execute and completion_stage. Accepts one executed micro-op per handshake. ALU ops pass through in one cycle. Loads and stores run a req/ack transaction on the data-memory port. Produces a registered, single-cycle completion record (65-bit value with valid in bit 64, 4-bit flags, ROB tag, save_cond) that completion_stage consumes with no backpressure.

Parameters:
ROBsize, 32, number of ROB entries
ROBsizeLog, $clog2(ROBsize+1), ROB tag width; tag 0 = no instruction
STALL_W, 16, width of memory-stall counter

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
flush_i  in  1  ROB mispredict flush; cancels in-flight op
exValid_i  in  1  execute presents an op
exReady_o  out  1  stage can accept (state IDLE)
exResult_i  in  64  ALU result, or effective address for load/store
exStoreData_i  in  64  store data
exFlags_i  in  4  condition flags from ALU
exSaveCond_i  in  1  op writes flags
exIsLoad_i  in  1  op is 64-bit load
exIsStore_i  in  1  op is 64-bit store
exROBTag_i  in  ROBsizeLog  destination ROB tag
memReq_o  out  1  memory request, held until ack
memWe_o  out  1  1 = write
memAddr_o  out  64  memory address
memWData_o  out  64  write data
memAck_i  in  1  memory accepts/completes request this cycle
memRData_i  in  64  load data, valid with memAck_i
dataToComp_o  out  65  [63:0] result, [64] completion valid pulse
flagsToComp_o  out  4  flags
ROBTagToComp_o  out  ROBsizeLog  ROB tag; 0 when no valid pulse
saveCondToComp_o  out  1  save_cond
memStallCount_o  out  STALL_W  saturating count of MEM_WAIT cycles

Behaviour:
- Clock and reset: one clock, clk_i. Reset reset_i is asynchronous, active-high.
- Reset values:
  - State IDLE.
  - All outputs 0, except exReady_o = 1 (combinational from IDLE).
  - memStallCount_o = 0.
- Accept rule: accept = exValid_i & exReady_o & ~flush_i.
  - An accepted op with exROBTag_i == 0 is a bubble: consumed, no output, no memory access.
- FSM states: IDLE, MEM_WAIT, DRAIN.
- IDLE, accepted ALU op (neither load nor store):
  - Next cycle: dataToComp_o = {1, exResult_i}, plus flags, tag and saveCond.
  - Latency 1. Stay IDLE. Back-to-back accepts give back-to-back pulses.
- IDLE, accepted load/store:
  - Latch tag, flags, saveCond, address, wdata, kind. Go to MEM_WAIT.
  - memReq_o = 1 from the next cycle; memAddr_o, memWe_o, memWData_o are stable while memReq_o is high.
- MEM_WAIT:
  - memReq_o = 1. memStallCount_o increments each cycle, saturating at all-ones.
  - On memAck_i (ack possible in the first req cycle): memReq_o drops next cycle; return to IDLE.
  - Next cycle: valid pulse. Data = memRData_i for a load, 64'h0 for a store. Flags and saveCond are the latched values.
- flush_i:
  - In IDLE: no accept; the pending output pulse from the previous cycle's accept is suppressed (valid 0, tag 0).
  - In MEM_WAIT without same-cycle ack: go to DRAIN.
  - In MEM_WAIT with same-cycle ack: return to IDLE, no pulse.
- DRAIN: memReq_o stays 1 until memAck_i (a bus transaction is never abandoned). On ack, return to IDLE with no output pulse. exReady_o = 0.
- Pulse rules:
  - Valid bit 64 is high exactly one cycle per completed op.
  - When bit 64 = 0: ROBTagToComp_o = 0 and saveCondToComp_o = 0; data and flags are don't-care but driven 0.
- Simultaneous flush and accept: flush wins; op is dropped; execute must not assume acceptance.
- Reset mid-transaction: state returns to IDLE, memReq_o drops immediately (async). The memory side must tolerate an abandoned request.

Decomposition:
- Shared package mem_pkg:
  - State enum mem_state_e {IDLE, MEM_WAIT, DRAIN}.
  - Completion record struct {logic [64:0] data; logic [3:0] flags; logic [ROBsizeLog-1:0] tag; logic saveCond}.
  - Constant NO_ROB_TAG = 0.
- One natural sub-module: mem_stage_outreg, the completion output register with suppress/flush and tag-zeroing logic.
- The FSM and stall counter stay in the top module.

Test Plan:
- ALU pass-through: exResult=64'hDEAD_BEEF, flags=4'b0101, saveCond=1, tag=5 at cycle N → cycle N+1 dataToComp_o = {1, 64'hDEAD_BEEF}, flags 0101, tag 5, saveCond 1. Cycle N+2 valid 0, tag 0.
- Load, ack after 3 cycles: addr 0x100, memRData = 64'h1234 with ack.
  - memReq high 3 cycles, memWe 0, memAddr 0x100.
  - Pulse data 64'h1234, tag 7, one cycle after ack.
  - memStallCount_o = 3. exReady_o low throughout.
- Store with same-cycle ack: addr 0x40, wdata 0xAA, ack on first req cycle → memWe 1, memWData 0xAA; next cycle pulse data 0, tag 9; exReady_o 1 after.
- Flush during MEM_WAIT: load tag 3, flush on req cycle 2, ack on cycle 4 → memReq held through ack, no pulse ever carries tag 3; stage accepts again the cycle after ack.
- Bubble and flush-vs-accept: exValid with tag 0 → no pulse, no memReq. exValid with tag 6 plus flush_i in the same cycle → no pulse.
- Async reset in MEM_WAIT: memReq_o and all outputs 0 immediately without a clock edge; exReady_o 1; memStallCount_o 0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory stage
// State encoding, completion record layout and the "no instruction" ROB tag.
package mem_pkg;

   localparam int ROB_SIZE  = 32;
   localparam int ROB_TAG_W = $clog2(ROB_SIZE + 1);

   localparam logic [ROB_TAG_W-1:0] NO_ROB_TAG = '0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic [64:0]          data;
      logic [3:0]           flags;
      logic [ROB_TAG_W-1:0] tag;
      logic                 saveCond;
   } comp_rec_t;

endpackage

// File: rtl/mem_stage_outreg.sv
// rtl/mem_stage_outreg.sv - completion output register
// Holds one single-cycle completion pulse; a flush in the pulse cycle hides it and zeroes the record.
module mem_stage_outreg
   import mem_pkg::*;
#(
   parameter int TAG_W = ROB_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             capture,
   input  logic [63:0]      result,
   input  logic [3:0]       flags,
   input  logic [TAG_W-1:0] tag,
   input  logic             save_cond,
   output logic [64:0]      comp_data,
   output logic [3:0]       comp_flags,
   output logic [TAG_W-1:0] comp_tag,
   output logic             comp_save_cond
);

   logic             valid_q;
   logic [63:0]      data_q;
   logic [3:0]       flags_q;
   logic [TAG_W-1:0] tag_q;
   logic             save_q;
   logic             show;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
         tag_q   <= TAG_W'(NO_ROB_TAG);
         save_q  <= 1'b0;
      end else if (capture) begin
         valid_q <= 1'b1;
         data_q  <= result;
         flags_q <= flags;
         tag_q   <= tag;
         save_q  <= save_cond;
      end else begin
         valid_q <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
         tag_q   <= TAG_W'(NO_ROB_TAG);
         save_q  <= 1'b0;
      end
   end

   // A mispredict flush arriving while the pulse is on the wire cancels it.
   assign show           = valid_q & ~flush;
   assign comp_data      = show ? {1'b1, data_q} : 65'd0;
   assign comp_flags     = show ? flags_q : 4'd0;
   assign comp_tag       = show ? tag_q : TAG_W'(NO_ROB_TAG);
   assign comp_save_cond = show & save_q;

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline stage between execute and completion
// ALU ops complete in one cycle; loads/stores run a req/ack transaction that is never abandoned.
module memory_stage
   import mem_pkg::*;
#(
   parameter int ROBsize    = 32,
   parameter int ROBsizeLog = $clog2(ROBsize + 1),
   parameter int STALL_W    = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   input  logic                  exValid_i,
   output logic                  exReady_o,
   input  logic [63:0]           exResult_i,
   input  logic [63:0]           exStoreData_i,
   input  logic [3:0]            exFlags_i,
   input  logic                  exSaveCond_i,
   input  logic                  exIsLoad_i,
   input  logic                  exIsStore_i,
   input  logic [ROBsizeLog-1:0] exROBTag_i,
   output logic                  memReq_o,
   output logic                  memWe_o,
   output logic [63:0]           memAddr_o,
   output logic [63:0]           memWData_o,
   input  logic                  memAck_i,
   input  logic [63:0]           memRData_i,
   output logic [64:0]           dataToComp_o,
   output logic [3:0]            flagsToComp_o,
   output logic [ROBsizeLog-1:0] ROBTagToComp_o,
   output logic                  saveCondToComp_o,
   output logic [STALL_W-1:0]    memStallCount_o
);

   mem_state_e            state;
   logic                  lat_load;
   logic [3:0]            lat_flags;
   logic [ROBsizeLog-1:0] lat_tag;
   logic                  lat_save;

   logic                  accept;
   logic                  is_bubble;
   logic                  is_mem;
   logic                  mem_start;
   logic                  alu_done;
   logic                  mem_done;

   logic                  cap;
   logic [63:0]           cap_data;
   logic [3:0]            cap_flags;
   logic [ROBsizeLog-1:0] cap_tag;
   logic                  cap_save;

   assign exReady_o = (state == IDLE);
   assign accept    = exValid_i & exReady_o & ~flush_i;
   assign is_bubble = (exROBTag_i == ROBsizeLog'(NO_ROB_TAG));
   assign is_mem    = exIsLoad_i | exIsStore_i;
   assign mem_start = accept & ~is_bubble & is_mem;
   assign alu_done  = accept & ~is_bubble & ~is_mem;
   assign mem_done  = (state == MEM_WAIT) & memAck_i & ~flush_i;

   always_comb begin
      cap       = alu_done | mem_done;
      cap_data  = 64'd0;
      cap_flags = lat_flags;
      cap_tag   = lat_tag;
      cap_save  = lat_save;
      if (alu_done) begin
         cap_data  = exResult_i;
         cap_flags = exFlags_i;
         cap_tag   = exROBTag_i;
         cap_save  = exSaveCond_i;
      end else if (lat_load) begin
         cap_data  = memRData_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state           <= IDLE;
         memReq_o        <= 1'b0;
         memWe_o         <= 1'b0;
         memAddr_o       <= '0;
         memWData_o      <= '0;
         lat_load        <= 1'b0;
         lat_flags       <= '0;
         lat_tag         <= ROBsizeLog'(NO_ROB_TAG);
         lat_save        <= 1'b0;
         memStallCount_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_start) begin
                  state      <= MEM_WAIT;
                  memReq_o   <= 1'b1;
                  memWe_o    <= ~exIsLoad_i;
                  memAddr_o  <= exResult_i;
                  memWData_o <= exStoreData_i;
                  lat_load   <= exIsLoad_i;
                  lat_flags  <= exFlags_i;
                  lat_tag    <= exROBTag_i;
                  lat_save   <= exSaveCond_i;
               end
            end
            MEM_WAIT: begin
               if (memStallCount_o != '1)
                  memStallCount_o <= memStallCount_o + STALL_W'(1);
               if (memAck_i) begin
                  state      <= IDLE;
                  memReq_o   <= 1'b0;
                  memWe_o    <= 1'b0;
                  memAddr_o  <= '0;
                  memWData_o <= '0;
               end else if (flush_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Flushed op: finish the bus handshake but report nothing.
               if (memAck_i) begin
                  state      <= IDLE;
                  memReq_o   <= 1'b0;
                  memWe_o    <= 1'b0;
                  memAddr_o  <= '0;
                  memWData_o <= '0;
               end
            end
            default: begin
               state    <= IDLE;
               memReq_o <= 1'b0;
            end
         endcase
      end
   end

   mem_stage_outreg #(
      .TAG_W(ROBsizeLog)
   ) u_outreg (
      .clk            (clk_i),
      .rst            (reset_i),
      .flush          (flush_i),
      .capture        (cap),
      .result         (cap_data),
      .flags          (cap_flags),
      .tag            (cap_tag),
      .save_cond      (cap_save),
      .comp_data      (dataToComp_o),
      .comp_flags     (flagsToComp_o),
      .comp_tag       (ROBTagToComp_o),
      .comp_save_cond (saveCondToComp_o)
   );

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
// Vector table for ALU traffic, directed memory corner cases, then random traffic against a model.
module tb_memory_stage;
   import mem_pkg::*;

   localparam int TW = ROB_TAG_W;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          flush_i;
   logic          exValid_i;
   logic          exReady_o;
   logic [63:0]   exResult_i;
   logic [63:0]   exStoreData_i;
   logic [3:0]    exFlags_i;
   logic          exSaveCond_i;
   logic          exIsLoad_i;
   logic          exIsStore_i;
   logic [TW-1:0] exROBTag_i;
   logic          memReq_o;
   logic          memWe_o;
   logic [63:0]   memAddr_o;
   logic [63:0]   memWData_o;
   logic          memAck_i;
   logic [63:0]   memRData_i;
   logic [64:0]   dataToComp_o;
   logic [3:0]    flagsToComp_o;
   logic [TW-1:0] ROBTagToComp_o;
   logic          saveCondToComp_o;
   logic [15:0]   memStallCount_o;

   memory_stage dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
      .exValid_i(exValid_i), .exReady_o(exReady_o),
      .exResult_i(exResult_i), .exStoreData_i(exStoreData_i),
      .exFlags_i(exFlags_i), .exSaveCond_i(exSaveCond_i),
      .exIsLoad_i(exIsLoad_i), .exIsStore_i(exIsStore_i),
      .exROBTag_i(exROBTag_i),
      .memReq_o(memReq_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
      .memWData_o(memWData_o), .memAck_i(memAck_i), .memRData_i(memRData_i),
      .dataToComp_o(dataToComp_o), .flagsToComp_o(flagsToComp_o),
      .ROBTagToComp_o(ROBTagToComp_o), .saveCondToComp_o(saveCondToComp_o),
      .memStallCount_o(memStallCount_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          valid;
      logic          flush;
      logic [TW-1:0] tag;
      logic [63:0]   res;
      logic [3:0]    flags;
      logic          save;
      comp_rec_t     exp;
   } vec_t;

   vec_t tbl [9];

   function automatic comp_rec_t mk(input logic v, input logic [63:0] d, input logic [3:0] f,
                                    input logic [TW-1:0] t, input logic s);
      comp_rec_t r;
      r.data     = {v, d};
      r.flags    = f;
      r.tag      = t;
      r.saveCond = s;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_pulse(input string name, input comp_rec_t e);
      chk({name, ".valid"}, 64'(dataToComp_o[64]), 64'(e.data[64]));
      chk({name, ".data"},  dataToComp_o[63:0], e.data[63:0]);
      chk({name, ".flags"}, 64'(flagsToComp_o), 64'(e.flags));
      chk({name, ".tag"},   64'(ROBTagToComp_o), 64'(e.tag));
      chk({name, ".save"},  64'(saveCondToComp_o), 64'(e.saveCond));
   endtask

   task automatic idle_inputs();
      flush_i = 0; exValid_i = 0; exResult_i = '0; exStoreData_i = '0;
      exFlags_i = '0; exSaveCond_i = 0; exIsLoad_i = 0; exIsStore_i = 0;
      exROBTag_i = '0; memAck_i = 0; memRData_i = '0;
   endtask

   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_i);
   endtask

   task automatic issue(input logic ld, input logic st, input logic [TW-1:0] t, input logic [63:0] r,
                        input logic [63:0] sd, input logic [3:0] f, input logic s);
      exValid_i = 1; exIsLoad_i = ld; exIsStore_i = st; exROBTag_i = t;
      exResult_i = r; exStoreData_i = sd; exFlags_i = f; exSaveCond_i = s;
   endtask

   // model state for the random phase
   bit          m_busy, m_drop, m_load;
   logic [63:0] m_addr, m_wdata;
   logic [3:0]  m_flags;
   logic [TW-1:0] m_tag;
   logic        m_save, m_we;
   comp_rec_t   m_pulse, nxt, exp_now;
   int          m_stall;

   initial begin
      idle_inputs();
      reset_i = 1;
      #12;
      chk("reset.ready", 64'(exReady_o), 64'd1);
      chk("reset.req", 64'(memReq_o), 64'd0);
      chk("reset.stall", 64'(memStallCount_o), 64'd0);
      chk_pulse("reset.pulse", '0);
      mid();
      reset_i = 0;
      next();

      tbl[0] = '{1, 0, 6'd5,  64'hDEAD_BEEF, 4'b0101, 1, '0};
      tbl[1] = '{0, 0, 6'd0,  64'h0,         4'h0,    0, mk(1, 64'hDEAD_BEEF, 4'b0101, 6'd5, 1)};
      tbl[2] = '{1, 0, 6'd10, 64'h1111,      4'hA,    0, '0};
      tbl[3] = '{1, 0, 6'd11, 64'h2222,      4'h3,    1, mk(1, 64'h1111, 4'hA, 6'd10, 0)};
      tbl[4] = '{1, 0, 6'd0,  64'h3333,      4'h7,    1, mk(1, 64'h2222, 4'h3, 6'd11, 1)};
      tbl[5] = '{1, 1, 6'd6,  64'h4444,      4'h1,    1, '0};
      tbl[6] = '{1, 0, 6'd12, 64'h5555,      4'hF,    1, '0};
      tbl[7] = '{0, 1, 6'd0,  64'h0,         4'h0,    0, '0};
      tbl[8] = '{0, 0, 6'd0,  64'h0,         4'h0,    0, '0};

      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         if (tbl[i].valid) issue(0, 0, tbl[i].tag, tbl[i].res, 64'h0, tbl[i].flags, tbl[i].save);
         flush_i = tbl[i].flush;
         mid();
         chk($sformatf("tbl%0d.ready", i), 64'(exReady_o), 64'd1);
         chk($sformatf("tbl%0d.req", i), 64'(memReq_o), 64'd0);
         chk_pulse($sformatf("tbl%0d", i), tbl[i].exp);
         next();
      end

      // load, ack on the third request cycle
      idle_inputs();
      issue(1, 0, 6'd7, 64'h100, 64'h0, 4'h2, 1);
      mid();
      chk("ld.ready0", 64'(exReady_o), 64'd1);
      next();
      idle_inputs();
      for (int c = 1; c <= 3; c++) begin
         memAck_i = (c == 3);
         memRData_i = (c == 3) ? 64'h1234 : {$urandom, $urandom};
         mid();
         chk($sformatf("ld.req%0d", c), 64'(memReq_o), 64'd1);
         chk($sformatf("ld.we%0d", c), 64'(memWe_o), 64'd0);
         chk($sformatf("ld.addr%0d", c), memAddr_o, 64'h100);
         chk($sformatf("ld.ready%0d", c), 64'(exReady_o), 64'd0);
         chk_pulse($sformatf("ld.nopulse%0d", c), '0);
         next();
      end
      idle_inputs();
      mid();
      chk_pulse("ld.pulse", mk(1, 64'h1234, 4'h2, 6'd7, 1));
      chk("ld.req_drop", 64'(memReq_o), 64'd0);
      chk("ld.ready_after", 64'(exReady_o), 64'd1);
      chk("ld.stall", 64'(memStallCount_o), 64'd3);
      next();

      // store, ack in the first request cycle
      issue(0, 1, 6'd9, 64'h40, 64'hAA, 4'hC, 0);
      next();
      idle_inputs();
      memAck_i = 1;
      mid();
      chk("st.req", 64'(memReq_o), 64'd1);
      chk("st.we", 64'(memWe_o), 64'd1);
      chk("st.addr", memAddr_o, 64'h40);
      chk("st.wdata", memWData_o, 64'hAA);
      next();
      idle_inputs();
      mid();
      chk_pulse("st.pulse", mk(1, 64'h0, 4'hC, 6'd9, 0));
      chk("st.ready", 64'(exReady_o), 64'd1);
      chk("st.stall", 64'(memStallCount_o), 64'd4);
      next();

      // flush during MEM_WAIT, ack two cycles later
      issue(1, 0, 6'd3, 64'h200, 64'h0, 4'h6, 1);
      next();
      idle_inputs();
      for (int c = 1; c <= 4; c++) begin
         flush_i = (c == 2);
         memAck_i = (c == 4);
         memRData_i = 64'h99;
         mid();
         chk($sformatf("fl.req%0d", c), 64'(memReq_o), 64'd1);
         chk($sformatf("fl.ready%0d", c), 64'(exReady_o), 64'd0);
         chk_pulse($sformatf("fl.nopulse%0d", c), '0);
         next();
      end
      idle_inputs();
      issue(0, 0, 6'd4, 64'h55, 64'h0, 4'h1, 1);
      mid();
      chk("fl.ready_after", 64'(exReady_o), 64'd1);
      chk("fl.req_after", 64'(memReq_o), 64'd0);
      chk_pulse("fl.no_tag3", '0);
      chk("fl.stall", 64'(memStallCount_o), 64'd6);
      next();
      idle_inputs();
      mid();
      chk_pulse("fl.alu_pulse", mk(1, 64'h55, 4'h1, 6'd4, 1));
      next();

      // asynchronous reset while a load is waiting
      issue(1, 0, 6'd8, 64'h300, 64'h0, 4'h0, 0);
      next();
      idle_inputs();
      mid();
      chk("ar.req_before", 64'(memReq_o), 64'd1);
      #1 reset_i = 1;
      #1;
      chk("ar.req", 64'(memReq_o), 64'd0);
      chk("ar.ready", 64'(exReady_o), 64'd1);
      chk("ar.stall", 64'(memStallCount_o), 64'd0);
      chk("ar.addr", memAddr_o, 64'd0);
      chk_pulse("ar.pulse", '0);
      @(negedge clk_i);
      reset_i = 0;
      next();

      // random traffic against the model
      m_busy = 0; m_drop = 0; m_stall = 0; m_pulse = '0;
      m_load = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_flags = '0; m_tag = '0; m_save = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         exValid_i = ($urandom_range(0, 2) != 0);
         exIsLoad_i = (kind == 1);
         exIsStore_i = (kind == 2);
         exROBTag_i = ($urandom_range(0, 7) == 0) ? 6'd0 : TW'($urandom_range(1, ROB_SIZE));
         exResult_i = {$urandom, $urandom};
         exStoreData_i = {$urandom, $urandom};
         exFlags_i = 4'($urandom);
         exSaveCond_i = 1'($urandom);
         flush_i = ($urandom_range(0, 9) == 0);
         memAck_i = m_busy && ($urandom_range(0, 2) == 0);
         memRData_i = {$urandom, $urandom};
         mid();
         chk("rnd.ready", 64'(exReady_o), 64'(!m_busy));
         chk("rnd.req", 64'(memReq_o), 64'(m_busy));
         if (m_busy) begin
            chk("rnd.addr", memAddr_o, m_addr);
            chk("rnd.we", 64'(memWe_o), 64'(m_we));
            if (m_we) chk("rnd.wdata", memWData_o, m_wdata);
         end
         exp_now = (m_pulse.data[64] && !flush_i) ? m_pulse : '0;
         chk_pulse("rnd", exp_now);
         chk("rnd.stall", 64'(memStallCount_o), 64'(m_stall));

         nxt = '0;
         if (!m_busy) begin
            if (exValid_i && !flush_i && exROBTag_i != 0) begin
               if (kind == 0) begin
                  nxt = mk(1, exResult_i, exFlags_i, exROBTag_i, exSaveCond_i);
               end else begin
                  m_busy = 1; m_drop = 0; m_load = (kind == 1); m_we = (kind == 2);
                  m_addr = exResult_i; m_wdata = exStoreData_i;
                  m_flags = exFlags_i; m_tag = exROBTag_i; m_save = exSaveCond_i;
               end
            end
         end else begin
            if (!m_drop && m_stall < 65535) m_stall++;
            if (memAck_i) begin
               m_busy = 0;
               if (!m_drop && !flush_i)
                  nxt = mk(1, m_load ? memRData_i : 64'h0, m_flags, m_tag, m_save);
            end else if (flush_i) begin
               m_drop = 1;
            end
         end
         m_pulse = nxt;
         next();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
